// File: rtl/tohost_monitor.sv
// rtl/tohost_monitor.sv - round-robin tohost poller reporting a pass/fail/timeout verdict
// Optional TOHOST_CLEAR_EN: write tohost back to 0 after every nonzero read.
module tohost_monitor #(
  parameter int          NCORES   = 1,
  parameter int          XLEN     = 64,
  parameter logic [11:0] CSR_ADDR = 12'h780,
  parameter int          CNT_W    = 64,
  parameter int          POLL_GAP = 0,
  localparam int         CW       = (NCORES > 1) ? $clog2(NCORES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] max_cycles,
  output logic             csr_req_valid,
  input  logic             csr_req_ready,
  output logic             csr_req_bits_rw,
  output logic [11:0]      csr_req_bits_addr,
  output logic [XLEN-1:0]  csr_req_bits_data,
  output logic [CW-1:0]    csr_req_core,
  input  logic             csr_resp_valid,
  output logic             csr_resp_ready,
  input  logic [XLEN-1:0]  csr_resp_bits,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CW-1:0]    fail_core,
  output logic [XLEN-1:0]  fail_code,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RESP = 3'd2,
`ifdef TOHOST_CLEAR_EN
    S_CLR  = 3'd3,
`endif
    S_GAP  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     idx, idx_n, next_idx, cand;
  logic [NCORES-1:0] pass_vec, pass_vec_n;
  logic              pass_r, pass_n, timeout_r, timeout_n;
  logic [CW-1:0]     fail_core_r, fail_core_n;
  logic [XLEN-1:0]   fail_code_r, fail_code_n;
  logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
  logic [31:0]       gap_cnt, gap_cnt_n;
  logic              req_valid, resp_ready;
  logic              failed_n, all_pass_hit, verdict_taken, tmo_hit, found;
`ifdef TOHOST_CLEAR_EN
  logic              req_rw, clr_sent, clr_sent_n, fail_pend, fail_pend_n;
`endif

  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);
  assign cnt_n   = (state == S_DONE) ? cnt : cnt_inc;
  // Compare against the value the counter is about to take so done and the frozen count land together.
  assign tmo_hit = (max_cycles != '0) && (cnt_inc > max_cycles) && (state != S_DONE);

  always_comb begin
    next_idx = idx;
    cand     = '0;
    found    = 1'b0;
    for (int k = 1; k <= NCORES; k++) begin
      cand = CW'((int'(idx) + k) % NCORES);
      if (!found && !pass_vec[cand]) begin
        next_idx = cand;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    pass_vec_n   = pass_vec;
    pass_n       = pass_r;
    timeout_n    = timeout_r;
    fail_core_n  = fail_core_r;
    fail_code_n  = fail_code_r;
    gap_cnt_n    = gap_cnt;
    req_valid    = 1'b0;
    resp_ready   = 1'b0;
    failed_n     = 1'b0;
    all_pass_hit = 1'b0;
`ifdef TOHOST_CLEAR_EN
    req_rw       = 1'b0;
    clr_sent_n   = clr_sent;
    fail_pend_n  = fail_pend;
`endif
    case (state)
      S_IDLE: if (enable) state_n = S_REQ;
      S_REQ: begin
        req_valid = 1'b1;
        if (csr_req_ready) state_n = S_RESP;
      end
      S_RESP: begin
        resp_ready = 1'b1;
        if (csr_resp_valid) begin
          if (csr_resp_bits > XLEN'(1)) begin
            fail_core_n = idx;
            fail_code_n = csr_resp_bits >> 1;
            failed_n    = 1'b1;
`ifdef TOHOST_CLEAR_EN
            fail_pend_n = 1'b1;
            state_n     = S_CLR;
`else
            state_n     = S_DONE;
`endif
          end else if (csr_resp_bits == XLEN'(1)) begin
            pass_vec_n[idx] = 1'b1;
`ifdef TOHOST_CLEAR_EN
            state_n = S_CLR;
`else
            state_n = S_GAP;
`endif
          end else begin
            state_n = S_GAP;
          end
        end
      end
`ifdef TOHOST_CLEAR_EN
      S_CLR: begin
        if (!clr_sent) begin
          req_valid = 1'b1;
          req_rw    = 1'b1;
          if (csr_req_ready) clr_sent_n = 1'b1;
        end else begin
          resp_ready = 1'b1;
          if (csr_resp_valid) begin
            clr_sent_n = 1'b0;
            state_n    = fail_pend ? S_DONE : S_GAP;
          end
        end
      end
`endif
      S_GAP: begin
        if (gap_cnt < 32'(POLL_GAP)) begin
          gap_cnt_n = gap_cnt + 32'd1;
        end else begin
          gap_cnt_n = '0;
          if (&pass_vec) begin
            all_pass_hit = 1'b1;
            pass_n       = 1'b1;
            state_n      = S_DONE;
          end else begin
            idx_n   = next_idx;
            state_n = enable ? S_REQ : S_IDLE;
          end
        end
      end
      S_DONE: state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase

    // A failure read (even one still clearing) or an all-pass outranks a same-cycle timeout.
    verdict_taken = failed_n || all_pass_hit;
`ifdef TOHOST_CLEAR_EN
    verdict_taken = verdict_taken || fail_pend;
`endif
    if (tmo_hit) begin
      state_n = S_DONE;
      if (!verdict_taken) timeout_n = 1'b1;
`ifdef TOHOST_CLEAR_EN
      clr_sent_n = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      pass_vec    <= '0;
      pass_r      <= 1'b0;
      timeout_r   <= 1'b0;
      fail_core_r <= '0;
      fail_code_r <= '0;
      cnt         <= '0;
      gap_cnt     <= '0;
`ifdef TOHOST_CLEAR_EN
      clr_sent    <= 1'b0;
      fail_pend   <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      pass_vec    <= pass_vec_n;
      pass_r      <= pass_n;
      timeout_r   <= timeout_n;
      fail_core_r <= fail_core_n;
      fail_code_r <= fail_code_n;
      cnt         <= cnt_n;
      gap_cnt     <= gap_cnt_n;
`ifdef TOHOST_CLEAR_EN
      clr_sent    <= clr_sent_n;
      fail_pend   <= fail_pend_n;
`endif
    end
  end

  assign csr_req_valid     = req_valid;
`ifdef TOHOST_CLEAR_EN
  assign csr_req_bits_rw   = req_rw;
`else
  assign csr_req_bits_rw   = 1'b0;
`endif
  assign csr_req_bits_addr = CSR_ADDR;
  assign csr_req_bits_data = '0;
  assign csr_req_core      = idx;
  assign csr_resp_ready    = resp_ready;
  assign done              = (state == S_DONE);
  assign pass              = pass_r;
  assign timeout           = timeout_r;
  assign fail_core         = fail_core_r;
  assign fail_code         = fail_code_r;
  assign cycle_count       = cnt;

endmodule

// File: doc/tohost_monitor.md
Name: tohost_monitor

Overview:
Synthesizable, multi-core successor to the simulation-only tohost poller. Round-robin polls each core's tohost CSR over the host CSR request/response channel and records per-core pass/fail. Reports a single pass/fail/timeout verdict with the failing core and code. Sits between the host interface and the top-level harness or FPGA status logic.

Parameters:
NCORES, 1, number of cores polled; core index width CW = max(1, clog2(NCORES))
XLEN, 64, CSR data width
CSR_ADDR, 12'h780, tohost CSR address
CNT_W, 64, cycle counter / max_cycles width
POLL_GAP, 0, idle cycles inserted after each completed poll before the next request

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
enable  input  1  start/continue polling; low holds the FSM in IDLE
max_cycles  input  CNT_W  timeout limit; 0 disables timeout
csr_req_valid  output  1  request valid
csr_req_ready  input  1  request accepted
csr_req_bits_rw  output  1  0 = read, 1 = write
csr_req_bits_addr  output  12  always CSR_ADDR
csr_req_bits_data  output  XLEN  write data (always 0)
csr_req_core  output  CW  target core index
csr_resp_valid  input  1  response valid
csr_resp_ready  output  1  response accept
csr_resp_bits  input  XLEN  read data
done  output  1  sticky verdict valid
pass  output  1  all cores wrote tohost = 1
timeout  output  1  cycle count exceeded max_cycles
fail_core  output  CW  core that reported a failure
fail_code  output  XLEN  tohost >> 1 of the failing core
cycle_count  output  CNT_W  cycles since reset deassertion, saturating

Behaviour:
- Reset: all outputs 0, core index 0, per-core pass vector 0, FSM in IDLE. Reset is asynchronous and may occur in any state, including mid-handshake. On reset, valid drops immediately and any outstanding response is abandoned.
- cycle_count: increments every cycle while reset is high and done is 0. Saturates at all-ones. Freezes when done = 1.
- FSM states: IDLE, REQ, RESP, CLR (feature only), GAP, DONE.
- IDLE:
  - enable = 1 → REQ.
- REQ:
  - csr_req_valid = 1, rw = 0, core = idx.
  - Valid/bits are held stable until csr_req_ready is sampled high; then → RESP.
- RESP:
  - csr_resp_ready = 1.
  - On csr_resp_valid, evaluate v = csr_resp_bits:
    - v == 0: no update.
    - v == 1: set pass_vec[idx].
    - v > 1: fail_core = idx, fail_code = v >> 1 (zero-extended), → DONE.
  - Otherwise → CLR if the feature is present and v != 0, else → GAP.
- GAP:
  - Waits POLL_GAP cycles; with POLL_GAP = 0 it is a single-cycle pass-through.
  - Then advances idx to the next core whose pass_vec bit is 0, wrapping from NCORES-1 to 0.
  - If all pass bits are set → DONE with pass = 1. Otherwise → REQ, or → IDLE if enable = 0.
- Cores that have passed are never polled again.
- Timeout: if max_cycles != 0 and cycle_count > max_cycles while not done → DONE with timeout = 1. Checked every cycle in every state and aborts any outstanding request.
- Same-cycle priority: failure response > all-pass > timeout.
- DONE: done = 1 is sticky; no further requests are issued. pass, timeout, fail_core and fail_code hold until reset.
- Exactly one of pass, timeout, or a failure (done & !pass & !timeout) is reported.
- csr_req_bits_data is always 0. csr_resp_ready is 0 outside RESP.

Optional Feature:
TOHOST_CLEAR_EN
- Defined:
  - After a nonzero read, CLR issues a write request (rw = 1, data = 0, same core and address) and holds it until ready is sampled high.
  - Then waits in CLR for the write's response (resp_ready = 1), discards its data, and → GAP. On a failure read, the clear is also issued before → DONE.
- Undefined: CLR state is absent, csr_req_bits_rw is tied 0, and a failure read goes directly to DONE.

Test Plan:
- NCORES = 1, ready always 1, responses 0, 0, then 1 → done = 1, pass = 1, fail_code = 0, exactly 3 read requests.
- NCORES = 4, core 2 returns 0x15, others return 0 → done = 1, pass = 0, fail_core = 2, fail_code = 0xA, no requests after that response.
- NCORES = 2, max_cycles = 50, responses always 0 → timeout = 1 when cycle_count = 51; cycle_count frozen at 51; no further requests.
- Backpressure: csr_req_ready low for 5 cycles → valid, core and addr stable across all 5 cycles; exactly one request accepted.
- Reset asserted while in RESP, then released with enable = 1 → outputs 0 during reset; polling restarts at core 0.
- TOHOST_CLEAR_EN, NCORES = 3, cores 0/1/2 return 1 → each pass read is followed by a write with rw = 1 and data = 0 to the same core; done = 1 and pass = 1 after the third clear completes.
